mem_led_stepper: RTL and testbench

- Parametrised memory-walk display for board bring-up.
- Steps an address pointer through a word-addressed memory over a synchronous read port and shows a selected byte lane of each word on the green LEDs.
- Drives a heartbeat on one red LED.
- Supports auto-step at a programmable rate, debounced single-step from a push button, and hold.
- Sits in the board top between the unified memory and the LEDs/keys.

---
 rtl/mem_led_stepper_if.sv | 13 +
 rtl/mem_led_stepper.sv | 176 +++++++++++++++++
 tb/tb_mem_led_stepper.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_led_stepper_if.sv
// Synchronous memory read port: the stepper masters the address/strobe and
// the memory returns the word one cycle after the strobe.
interface mem_led_stepper_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_addr, output mem_rd_en, input mem_rdata);
  modport slave  (input mem_addr, input mem_rd_en, output mem_rdata);
endinterface

// File: rtl/mem_led_stepper.sv
// Memory-walk display for board bring-up: steps a pointer through memory,
// shows one byte lane of each word on LEDG and blinks a heartbeat on LEDR0.
module mem_led_stepper #(
  parameter int CLK_HZ       = 50000000,
  parameter int STEP_HZ      = 2,
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int LED_W        = 8,
  parameter int LAST_ADDR    = 2999,
  parameter int DEBOUNCE_CYC = 1000000,
  localparam int NLANES      = DATA_W / LED_W,
  localparam int LANE_W      = (NLANES > 1) ? $clog2(NLANES) : 1
) (
  input  logic                 CLOCK_50,
  input  logic                 KEY0,
  input  logic [1:0]           mode,
  input  logic                 step_n,
  input  logic [LANE_W-1:0]    lane_sel,
  mem_led_stepper_if.master    mem,
  output logic [DATA_W-1:0]    word_q,
  output logic [ADDR_W-1:0]    cur_addr,
  output logic [LED_W-1:0]     LEDG,
  output logic                 LEDR0
);

  localparam int TICK_CYC = CLK_HZ / STEP_HZ;
  localparam int TCNT_W   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int DCNT_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  localparam logic [TCNT_W-1:0] TICK_LAST = TCNT_W'(TICK_CYC - 1);
  localparam logic [DCNT_W-1:0] DEB_LAST  = DCNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(LAST_ADDR);
  localparam logic [LANE_W:0]   NLANES_L  = (LANE_W + 1)'(NLANES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [TCNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic                ledr_q, ledr_d;
  logic                sync1_q, sync2_q;
  logic                btn_q, btn_d;
  logic [DCNT_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_en_q, rd_en_d;
  logic [DATA_W-1:0]   word_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [LED_W-1:0]    ledg_q, ledg_d;
  logic                tick_s;
  logic                press_s;
  logic                trig_s;
  logic [LANE_W-1:0]   idx_s;

  assign mem.mem_addr  = addr_q;
  assign mem.mem_rd_en = rd_en_q;
  assign cur_addr      = cur_addr_q;
  assign LEDG          = ledg_q;
  assign LEDR0         = ledr_q;

  // Free-running tick divider and heartbeat toggle.
  always_comb begin
    tick_s     = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_s ? {TCNT_W{1'b0}} : (tick_cnt_q + TCNT_W'(1));
    ledr_d     = tick_s ? ~ledr_q : ledr_q;
  end

  // Debouncer: a new level is accepted after DEBOUNCE_CYC consecutive samples
  // that differ from the accepted one; only the accepted press edge pulses.
  always_comb begin
    btn_d     = btn_q;
    deb_cnt_d = {DCNT_W{1'b0}};
    press_s   = 1'b0;
    if (sync2_q == btn_q) begin
      deb_cnt_d = {DCNT_W{1'b0}};
    end else if (deb_cnt_q == DEB_LAST) begin
      btn_d   = sync2_q;
      press_s = ~sync2_q;
    end else begin
      deb_cnt_d = deb_cnt_q + DCNT_W'(1);
    end
  end

  // Step trigger source selected by mode; hold modes never trigger.
  always_comb begin
    trig_s = 1'b0;
    case (mode)
      2'b00:   trig_s = tick_s;
      2'b01:   trig_s = press_s;
      default: trig_s = 1'b0;
    endcase
  end

  // Read FSM: strobe, wait for the 1-cycle read latency, then capture.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_en_d    = 1'b0;
    word_d     = word_q;
    cur_addr_d = cur_addr_q;
    ptr_d      = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (trig_s) begin
          addr_d  = ptr_q;
          rd_en_d = 1'b1;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        word_d     = mem.mem_rdata;
        cur_addr_d = addr_q;
        ptr_d      = (ptr_q == PTR_LAST) ? {ADDR_W{1'b0}} : (ptr_q + ADDR_W'(1));
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Lane select; out-of-range selects fall back to lane 0.
  always_comb begin
    idx_s  = ({1'b0, lane_sel} < NLANES_L) ? lane_sel : {LANE_W{1'b0}};
    ledg_d = LED_W'(word_q >> (32'(idx_s) * LED_W));
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, divider, synchroniser and debounce registers.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      tick_cnt_q <= {TCNT_W{1'b0}};
      ledr_q     <= 1'b0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      btn_q      <= 1'b1;
      deb_cnt_q  <= {DCNT_W{1'b0}};
      ptr_q      <= {ADDR_W{1'b0}};
      addr_q     <= {ADDR_W{1'b0}};
      rd_en_q    <= 1'b0;
      word_q     <= {DATA_W{1'b0}};
      cur_addr_q <= {ADDR_W{1'b0}};
      ledg_q     <= {LED_W{1'b0}};
    end else begin
      tick_cnt_q <= tick_cnt_d;
      ledr_q     <= ledr_d;
      sync1_q    <= step_n;
      sync2_q    <= sync1_q;
      btn_q      <= btn_d;
      deb_cnt_q  <= deb_cnt_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      rd_en_q    <= rd_en_d;
      word_q     <= word_d;
      cur_addr_q <= cur_addr_d;
      ledg_q     <= ledg_d;
    end
  end

endmodule

// File: tb/tb_mem_led_stepper.sv
// Directed + randomized bench for mem_led_stepper with a small behavioural
// model of the walk (pointer, memory contents, lane view, button acceptance).
module tb_mem_led_stepper;

  localparam int CLK_HZ  = 20;
  localparam int STEP_HZ = 2;
  localparam int TICK    = CLK_HZ / STEP_HZ;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;
  localparam int LED_W   = 8;
  localparam int LAST    = 3;
  localparam int DEB     = 4;
  localparam int LANE_W  = 2;

  logic               CLOCK_50 = 1'b0;
  logic               KEY0;
  logic [1:0]         mode;
  logic               step_n;
  logic [LANE_W-1:0]  lane_sel;
  logic [DATA_W-1:0]  word_q;
  logic [ADDR_W-1:0]  cur_addr;
  logic [LED_W-1:0]   LEDG;
  logic               LEDR0;

  mem_led_stepper_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  mem_led_stepper #(
    .CLK_HZ(CLK_HZ), .STEP_HZ(STEP_HZ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .LED_W(LED_W), .LAST_ADDR(LAST), .DEBOUNCE_CYC(DEB)
  ) dut (
    .CLOCK_50(CLOCK_50), .KEY0(KEY0), .mode(mode), .step_n(step_n),
    .lane_sel(lane_sel), .mem(mem_bus), .word_q(word_q), .cur_addr(cur_addr),
    .LEDG(LEDG), .LEDR0(LEDR0)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // 1-cycle synchronous read memory: word[a] = A0B0C0D0 + a
  always @(posedge CLOCK_50) begin
    if (mem_bus.mem_rd_en === 1'b1)
      mem_bus.mem_rdata <= 32'hA0B0C0D0 + 32'(mem_bus.mem_addr);
  end

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cyc    = 0;
  int last_rd = 0;
  int m_ptr  = 0;
  int m_cur  = 0;
  int rd_seen = 0;
  int rd_addr = 0;
  int toggles = 0;
  logic prev_ledr;

  function automatic logic [31:0] mword(input int a);
    return 32'hA0B0C0D0 + 32'(a);
  endfunction

  function automatic logic [31:0] lane_of(input logic [31:0] w, input int k);
    int kk;
    kk = (k < DATA_W / LED_W) ? k : 0;
    return (w >> (8 * kk)) & 32'h000000FF;
  endfunction

  function automatic int nxt(input int a);
    return (a == LAST) ? 0 : a + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge CLOCK_50);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      clk1();
      if (mem_bus.mem_rd_en === 1'b1) begin
        rd_seen++;
        rd_addr = int'(mem_bus.mem_addr);
      end
      if (LEDR0 !== prev_ledr) toggles++;
      prev_ledr = LEDR0;
    end
  endtask

  task automatic wait_read(input string tag);
    int waited;
    waited = 0;
    while (mem_bus.mem_rd_en !== 1'b1 && waited < 40) begin
      clk1();
      waited++;
    end
    chk({tag, "_rd_en"}, 32'(mem_bus.mem_rd_en), 32'd1);
  endtask

  // One full step: read strobe, capture 2 cycles later, LEDG one cycle after.
  task automatic do_step(input string tag, input int exp_gap);
    wait_read(tag);
    if (exp_gap > 0) chk({tag, "_gap"}, 32'(cyc - last_rd), 32'(exp_gap));
    last_rd = cyc;
    chk({tag, "_addr"}, 32'(mem_bus.mem_addr), 32'(m_ptr));
    clk1();
    clk1();
    chk({tag, "_cur"}, 32'(cur_addr), 32'(m_ptr));
    chk({tag, "_word"}, word_q, mword(m_ptr));
    m_cur = m_ptr;
    m_ptr = nxt(m_ptr);
    clk1();
    chk({tag, "_ledg"}, 32'(LEDG), lane_of(mword(m_cur), int'(lane_sel)));
  endtask

  initial begin
    int len;
    int k;
    KEY0 = 1'b0; mode = 2'b00; step_n = 1'b1; lane_sel = '0;
    #3;
    repeat (3) clk1();
    chk("rst_ledg", 32'(LEDG), 32'd0);
    chk("rst_ledr", 32'(LEDR0), 32'd0);
    chk("rst_word", word_q, 32'd0);
    chk("rst_cur", 32'(cur_addr), 32'd0);
    chk("rst_maddr", 32'(mem_bus.mem_addr), 32'd0);
    chk("rst_rden", 32'(mem_bus.mem_rd_en), 32'd0);

    // release: first tick after TICK cycles reads address 0
    KEY0 = 1'b1; cyc = 0; last_rd = 0; m_ptr = 0;
    do_step("first", TICK);
    chk("first_ledr", 32'(LEDR0), 32'd1);

    // auto walk with wrap after LAST
    for (int i = 0; i < 4; i++) do_step("auto", TICK);

    // single-step mode: short press ignored, long press and bounce give one step
    mode = 2'b01;
    rd_seen = 0; prev_ledr = LEDR0;
    step_n = 1'b0; run(3); step_n = 1'b1; run(20);
    chk("short_press", 32'(rd_seen), 32'd0);
    rd_seen = 0;
    step_n = 1'b0; run(10); step_n = 1'b1; run(20);
    chk("long_press", 32'(rd_seen), 32'd1);
    chk("long_addr", 32'(rd_addr), 32'(m_ptr));
    chk("long_cur", 32'(cur_addr), 32'(m_ptr));
    m_cur = m_ptr; m_ptr = nxt(m_ptr);
    rd_seen = 0;
    step_n = 1'b0; run(1); step_n = 1'b1; run(1);
    step_n = 1'b0; run(1); step_n = 1'b1; run(1);
    step_n = 1'b0; run(10); step_n = 1'b1; run(20);
    chk("bounce_press", 32'(rd_seen), 32'd1);
    chk("bounce_cur", 32'(cur_addr), 32'(m_ptr));
    chk("bounce_word", word_q, mword(m_ptr));
    m_cur = m_ptr; m_ptr = nxt(m_ptr);

    // lane selection shows one cycle after the change
    lane_sel = 2'd3; clk1();
    chk("lane3", 32'(LEDG), lane_of(mword(m_cur), 3));
    lane_sel = 2'd1; clk1();
    chk("lane1", 32'(LEDG), lane_of(mword(m_cur), 1));
    for (int i = 0; i < 6; i++) begin
      k = $urandom_range(0, 3);
      lane_sel = LANE_W'(k); clk1();
      chk("lane_rand", 32'(LEDG), lane_of(mword(m_cur), k));
    end
    lane_sel = '0;

    // hold: no reads, heartbeat keeps running
    mode = 2'b10;
    rd_seen = 0; toggles = 0; prev_ledr = LEDR0;
    run(50);
    chk("hold_reads", 32'(rd_seen), 32'd0);
    chk("hold_toggles", 32'(toggles), 32'd5);
    chk("hold_cur", 32'(cur_addr), 32'(m_cur));
    mode = 2'b00;
    do_step("resume", 0);
    do_step("resume2", TICK);

    // async reset while the read strobe is high
    wait_read("rst_mid");
    chk("rst_mid_addr", 32'(mem_bus.mem_addr), 32'(m_ptr));
    KEY0 = 1'b0;
    #2;
    chk("arst_rden", 32'(mem_bus.mem_rd_en), 32'd0);
    chk("arst_maddr", 32'(mem_bus.mem_addr), 32'd0);
    chk("arst_word", word_q, 32'd0);
    chk("arst_cur", 32'(cur_addr), 32'd0);
    chk("arst_ledg", 32'(LEDG), 32'd0);
    chk("arst_ledr", 32'(LEDR0), 32'd0);
    clk1(); clk1();
    KEY0 = 1'b1; cyc = 0; last_rd = 0; m_ptr = 0;
    do_step("post_rst", TICK);

    // random press lengths: accepted only when low for >= DEB samples
    mode = 2'b01;
    for (int i = 0; i < 8; i++) begin
      len = $urandom_range(1, 10);
      k = $urandom_range(0, 3);
      lane_sel = LANE_W'(k);
      rd_seen = 0;
      step_n = 1'b0; run(len); step_n = 1'b1; run(20);
      chk("rand_press", 32'(rd_seen), (len >= DEB) ? 32'd1 : 32'd0);
      if (len >= DEB) begin
        chk("rand_addr", 32'(rd_addr), 32'(m_ptr));
        chk("rand_cur", 32'(cur_addr), 32'(m_ptr));
        m_cur = m_ptr; m_ptr = nxt(m_ptr);
      end
      chk("rand_ledg", 32'(LEDG), lane_of(mword(m_cur), k));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
